muldiv_seq: RTL
===============

# muldiv_seq

- Sequential multiply/divide controller for the integer datapath.
- Executes MULTU, MULT, DIVU and DIV with one shared `addsub32` adder/subtractor, one operation per iteration.
- Results land in HI/LO holding registers.
- Sits beside the ALU and is used by the pipeline's multiply/divide stall logic through a start/busy/done handshake.

## Interface
Parameters:
- None; the datapath is fixed at 32 bits and 32 iterations.

Ports:
- `clk`  in  1  — clock; all state changes on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — request; sampled only while `busy`=0.
- `op`  in  2  — 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; captured with `start`.
- `a`  in  32  — multiplicand or dividend; captured with `start`.
- `b`  in  32  — multiplier or divisor; captured with `start`.
- `busy`  out  1  — an operation is in progress.
- `done`  out  1  — one-cycle pulse; `hi`/`lo` are valid in that cycle.
- `hi`  out  32  — product high word, or remainder.
- `lo`  out  32  — product low word, or quotient.
- `dz`  out  1  — divide-by-zero flag for the last completed operation.

## Operation
- Exactly one `addsub32` instance. Every add, subtract and negate goes through it (negate = 0 − x with sub=1).
- Carry/borrow is not an adder output. The controller reconstructs it from the operand and result MSBs:
  - add: `c = a31&b31 | (a31|b31)&~r31`
  - sub: `borrow = ~a31&b31 | (~a31|b31)&r31`
- States: IDLE, NEG_A, NEG_B, ITER, FIX_LO, FIX_HI, DONE.
- From IDLE or DONE, `start`=1 captures `op`, `a`, `b`, then branches:
  - DIVU/DIV with `b`==0 → DONE.
  - signed op → NEG_A.
  - unsigned op → ITER.
- NEG_A: replace A by 0−A if A[31]=1; record sa. NEG_B: same for B; record sb. Both states always occur for signed ops.
- ITER, iteration counter 0..31; leave after count 31.
  - Targets FIX_LO for signed ops, DONE for unsigned.
- Multiply, ITER (shift-add; {H,L} starts as {0, multiplier}):
  - if L[0]: (c,s) = H + M, else (c,s) = (0,H).
  - then {H,L} = {c, s, L[31:1]}.
- Divide, ITER (restoring; {R,Q} starts as {0, dividend}):
  - R' = {R[30:0], Q[31]}, ov = R[31], t = R' − D.
  - if ov | ~borrow: R = t, qbit = 1; else R = R', qbit = 0.
  - Q = {Q[30:0], qbit}.
- FIX_LO:
  - mult: negate L if sa^sb; save lz = (L==0) before the negate.
  - div: negate Q if sa^sb.
- FIX_HI:
  - mult: if sa^sb, H = lz ? 0−H : ~H.
  - div: negate R if sa.
- Operands of 0x80000000 negate to themselves and are treated as unsigned magnitude 2^31, which gives correct results.
- Divide by zero: `hi`=`a`, `lo`=0xFFFFFFFF, `dz`=1, no iterations.
- DONE: load `hi`/`lo` from the working registers; `done`=1 and `busy`=0 for one cycle; then IDLE unless `start` is accepted in that cycle.
- `start` while `busy`=1 is ignored; captured operands are not disturbed.

## Timing
- Reset values:
  - state IDLE
  - `busy`=0, `done`=0, `dz`=0
  - `hi`=0, `lo`=0
  - counter and working registers 0
- Reset asserted mid-operation aborts immediately; the next result needs a new `start`.
- `start` accepted at edge of cycle 0 → `busy`=1 from cycle 1.
- `done` cycle:
  - unsigned: cycle 33 (32 ITER cycles).
  - signed: cycle 37 (NEG_A, NEG_B, 32 ITER, FIX_LO, FIX_HI).
  - divide by zero: cycle 1.
- `busy`=1 in every state except IDLE and DONE.
- `hi`, `lo` and `dz` change only on entry to DONE and hold until the next DONE.
- A back-to-back `start` in the DONE cycle begins the next operation with no idle cycle. `dz` is updated only at that operation's DONE.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `done` at cycle 33, `hi`=0xFFFFFFFE, `lo`=0x00000001, `dz`=0.
- MULT a=−3 (0xFFFFFFFD), b=7 → `done` at cycle 37, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. MULT 0x80000000×0x80000000 → `hi`=0x40000000, `lo`=0.
- DIVU 100/7 → `lo`=14, `hi`=2, cycle 33. DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF, cycle 37.
- DIV a=0x12345678, b=0 → `done` at cycle 1, `dz`=1, `hi`=0x12345678, `lo`=0xFFFFFFFF. A following DIVU 9/3 clears `dz`, giving `lo`=3, `hi`=0.
- Start MULTU 5×6, pulse `start` with new operands at cycle 10 (ignored), then `start` DIVU 9/4 in the DONE cycle:
  - first result `lo`=30, `hi`=0.
  - second result `lo`=2, `hi`=1 at 33 cycles later.
- Assert `rst` at cycle 15 of a DIV → `busy`, `done`, `hi`, `lo` and `dz` read 0 asynchronously. After release, a new MULT 2×−2 gives `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFC.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential 32-bit multiply/divide unit (MULTU, MULT, DIVU, DIV) built around
// a single shared adder/subtractor; results are held in hi/lo until the next DONE.

module addsub32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        sub,
  output logic [31:0] r
);
  assign r = sub ? (x - y) : (x + y);
endmodule

module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dz
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] NEG_A  = 3'd1;
  localparam logic [2:0] NEG_B  = 3'd2;
  localparam logic [2:0] ITER   = 3'd3;
  localparam logic [2:0] FIX_LO = 3'd4;
  localparam logic [2:0] FIX_HI = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  // ra: multiplicand / dividend-quotient, rb: multiplier-low product / divisor
  logic [2:0]  state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [1:0]  op_r, op_nxt;
  logic [31:0] h, h_nxt, ra, ra_nxt, rb, rb_nxt;
  logic        sa, sa_nxt, sb, sb_nxt, lz, lz_nxt;
  logic [31:0] x_op, y_op, sum, rp, res_hi, res_lo;
  logic        sub_en, carry, borrow, dz_take;

  addsub32 u_addsub (
    .x   (x_op),
    .y   (y_op),
    .sub (sub_en),
    .r   (sum)
  );

  // The adder has no carry-out, so carry/borrow are recovered from the MSBs.
  assign carry  = (x_op[31] & y_op[31]) | ((x_op[31] | y_op[31]) & ~sum[31]);
  assign borrow = (~x_op[31] & y_op[31]) | ((~x_op[31] | y_op[31]) & sum[31]);
  assign rp     = {h[30:0], ra[31]};

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    x_op   = 32'd0;
    y_op   = 32'd0;
    sub_en = 1'b1;
    case (state)
      NEG_A:  y_op = ra;
      NEG_B:  y_op = rb;
      ITER: begin
        if (op_r[1]) begin
          x_op = rp;
          y_op = rb;
        end else begin
          x_op   = h;
          y_op   = ra;
          sub_en = 1'b0;
        end
      end
      FIX_LO: y_op = op_r[1] ? ra : rb;
      FIX_HI: y_op = h;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_r;
    h_nxt     = h;
    ra_nxt    = ra;
    rb_nxt    = rb;
    sa_nxt    = sa;
    sb_nxt    = sb;
    lz_nxt    = lz;
    dz_take   = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start) begin
          op_nxt = op;
          ra_nxt = a;
          rb_nxt = b;
          h_nxt  = 32'd0;
          cnt_nxt = 5'd0;
          sa_nxt = 1'b0;
          sb_nxt = 1'b0;
          lz_nxt = 1'b0;
          if (op[1] && (b == 32'd0)) begin
            state_nxt = DONE;
            dz_take   = 1'b1;
          end else if (op[0]) begin
            state_nxt = NEG_A;
          end else begin
            state_nxt = ITER;
          end
        end
      end
      NEG_A: begin
        state_nxt = NEG_B;
        sa_nxt    = ra[31];
        if (ra[31]) ra_nxt = sum;
      end
      NEG_B: begin
        state_nxt = ITER;
        sb_nxt    = rb[31];
        if (rb[31]) rb_nxt = sum;
      end
      ITER: begin
        cnt_nxt = cnt + 5'd1;
        if (op_r[1]) begin
          // h[31] is the bit shifted out of R: the shifted remainder exceeds D.
          if (h[31] | ~borrow) begin
            h_nxt  = sum;
            ra_nxt = {ra[30:0], 1'b1};
          end else begin
            h_nxt  = rp;
            ra_nxt = {ra[30:0], 1'b0};
          end
        end else if (rb[0]) begin
          h_nxt  = {carry, sum[31:1]};
          rb_nxt = {sum[0], rb[31:1]};
        end else begin
          h_nxt  = {1'b0, h[31:1]};
          rb_nxt = {h[0], rb[31:1]};
        end
        if (cnt == 5'd31) state_nxt = op_r[0] ? FIX_LO : DONE;
      end
      FIX_LO: begin
        state_nxt = FIX_HI;
        if (op_r[1]) begin
          if (sa ^ sb) ra_nxt = sum;
        end else begin
          lz_nxt = (rb == 32'd0);
          if (sa ^ sb) rb_nxt = sum;
        end
      end
      FIX_HI: begin
        state_nxt = DONE;
        // 64-bit negate: the high word only takes the +1 when the low word was zero.
        if (op_r[1]) begin
          if (sa) h_nxt = sum;
        end else if (sa ^ sb) begin
          h_nxt = lz ? sum : ~h;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (dz_take) begin
      res_hi = a;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = h_nxt;
      res_lo = op_nxt[1] ? ra_nxt : rb_nxt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
      op_r  <= 2'd0;
      h     <= 32'd0;
      ra    <= 32'd0;
      rb    <= 32'd0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      lz    <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      dz    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op_r  <= op_nxt;
      h     <= h_nxt;
      ra    <= ra_nxt;
      rb    <= rb_nxt;
      sa    <= sa_nxt;
      sb    <= sb_nxt;
      lz    <= lz_nxt;
      if (state_nxt == DONE) begin
        hi <= res_hi;
        lo <= res_lo;
        dz <= dz_take;
      end
    end
  end
endmodule
